// File: rtl/spi_frame_loader_if.sv
// spi_frame_loader_if
//   Bundles the signals between the SPI receiver / display FSM side and the
//   frame loader, plus the loader's outputs towards EBRController.
//   master modport : the upstream side (drives frame, data_ready, frame_end)
//   slave  modport : the loader itself
// Signals
//   data_frame  NCOLS*YWID  packed column frame, stable while data_ready is high
//   data_ready  1           level, high while a complete frame is held
//   frame_end   1           one-cycle pulse when the display row address wraps
//   y_out       YWID x NCOLS unpacked column heights
//   w_en        1           one-cycle write strobe
//   get_buffer  1           one-cycle buffer-swap strobe
//   busy        1           loader is not idle
//   frame_count 16          completed swaps (wrapping)
//   drop_count  8           rejected frames (saturating)
interface spi_frame_loader_if #(
    parameter int NCOLS = 64,
    parameter int YWID  = 6
);
    logic [NCOLS*YWID-1:0] data_frame;
    logic                  data_ready;
    logic                  frame_end;
    logic [YWID-1:0]       y_out [NCOLS];
    logic                  w_en;
    logic                  get_buffer;
    logic                  busy;
    logic [15:0]           frame_count;
    logic [7:0]            drop_count;

    modport master (
        output data_frame, data_ready, frame_end,
        input  y_out, w_en, get_buffer, busy, frame_count, drop_count
    );

    modport slave (
        input  data_frame, data_ready, frame_end,
        output y_out, w_en, get_buffer, busy, frame_count, drop_count
    );
endinterface

// File: rtl/spi_frame_loader.sv
// spi_frame_loader
//   Takes the column frame from the SPI receiver on each rising edge of
//   data_ready, unpacks it into NCOLS column heights, writes it to the EBR
//   back buffer with a one-cycle w_en, then requests the buffer swap on the
//   next display frame boundary (or after SWAP_TO cycles if none arrives).
// Ports
//   clk    in  system clock, rising edge
//   reset  in  asynchronous, active-low reset
//   bus    slave modport of spi_frame_loader_if (frame in, strobes/status out)
module spi_frame_loader #(
    parameter int NCOLS   = 64,
    parameter int YWID    = 6,
    parameter int MIRROR  = 0,
    parameter int SWAP_TO = 4096
) (
    input  logic                  clk,
    input  logic                  reset,
    spi_frame_loader_if.slave     bus
);
    localparam int TW = (SWAP_TO > 1) ? $clog2(SWAP_TO) : 1;
    localparam logic [TW-1:0] TO_LAST = TW'(SWAP_TO - 1);

    typedef enum logic [2:0] {
        IDLE,
        CAPTURE,
        WRITE,
        WAIT_SWAP,
        SWAP
    } state_t;

    state_t          state_reg, state_next;
    logic            rdy_reg;
    logic            new_frame;
    logic [TW-1:0]   to_cnt_reg, to_cnt_next;
    logic [15:0]     frame_count_reg;
    logic [7:0]      drop_count_reg;
    logic [YWID-1:0] field [NCOLS];
    logic [YWID-1:0] y_reg [NCOLS];

    // Column 0 sits in the most significant field (first bit shifted in).
    // With MIRROR the output order is reversed, so output k reads the
    // field of column NCOLS-1-k.
    generate
        for (genvar gi = 0; gi < NCOLS; gi++) begin : g_cols
            localparam int SRC = (MIRROR != 0) ? (NCOLS - 1 - gi) : gi;
            assign field[gi]     = bus.data_frame[NCOLS*YWID-1-SRC*YWID -: YWID];
            assign bus.y_out[gi] = y_reg[gi];
        end
    endgenerate

    assign new_frame = bus.data_ready & ~rdy_reg;

    always_comb begin
        state_next  = state_reg;
        to_cnt_next = to_cnt_reg;
        case (state_reg)
            IDLE: begin
                if (new_frame) state_next = CAPTURE;
            end
            CAPTURE: begin
                state_next = WRITE;
            end
            WRITE: begin
                to_cnt_next = '0;
                state_next  = WAIT_SWAP;
            end
            WAIT_SWAP: begin
                // frame_end and timeout in the same cycle collapse into one swap
                if (bus.frame_end || (to_cnt_reg == TO_LAST)) begin
                    state_next = SWAP;
                end else begin
                    to_cnt_next = to_cnt_reg + 1'b1;
                end
            end
            SWAP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg       <= IDLE;
            // Held at 1 so a data_ready already high at release is not an edge
            rdy_reg         <= 1'b1;
            to_cnt_reg      <= '0;
            frame_count_reg <= '0;
            drop_count_reg  <= '0;
            for (int i = 0; i < NCOLS; i++) y_reg[i] <= '0;
        end else begin
            state_reg  <= state_next;
            rdy_reg    <= bus.data_ready;
            to_cnt_reg <= to_cnt_next;
            if (state_reg == CAPTURE) begin
                for (int i = 0; i < NCOLS; i++) y_reg[i] <= field[i];
            end
            if (state_reg == SWAP) begin
                frame_count_reg <= frame_count_reg + 16'd1;
            end
            // Any frame edge outside IDLE is an overrun and is discarded
            if (new_frame && (state_reg != IDLE) && (drop_count_reg != 8'hFF)) begin
                drop_count_reg <= drop_count_reg + 8'd1;
            end
        end
    end

    // Strobes decode straight from state, so an asynchronous reset kills
    // them immediately and they can never overlap.
    assign bus.w_en        = (state_reg == WRITE);
    assign bus.get_buffer  = (state_reg == SWAP);
    assign bus.busy        = (state_reg != IDLE);
    assign bus.frame_count = frame_count_reg;
    assign bus.drop_count  = drop_count_reg;
endmodule
